// File: rtl/int_ack_master_pkg.sv
// Shared definitions for the interrupt-acknowledge master: FSM state encoding,
// sequencing counter width, INTA idle level and a counter-load helper.
package int_ack_master_pkg;

  localparam int unsigned CNT_W = 4;

  // INTA is active-low; this is its level whenever no pulse is being driven.
  localparam logic INTA_IDLE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACK1    = 3'd1,
    ST_GAP     = 3'd2,
    ST_ACK2    = 3'd3,
    ST_HANDOFF = 3'd4,
    ST_REARM   = 3'd5
  } state_e;

  // Counter reload for a phase lasting cyc cycles (counts down to zero).
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cyc);
    return CNT_W'(cyc - 32'd1);
  endfunction

endpackage

// File: rtl/int_ack_master_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronized).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/int_ack_master.sv
// Interrupt-acknowledge master: on a synchronized, enabled interrupt request it
// issues two timed active-low INTA pulses, captures the vector from D at the end
// of the second pulse, presents it to the CPU core with a valid/ready handshake,
// then holds INTA high for a re-arm period before accepting the next request.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   INT             asynchronous interrupt request (active-high)
//   int_en          CPU interrupt enable, only looked at while idle
//   D[7:0]          data bus carrying the vector during the second pulse
//   INTA            registered active-low acknowledge strobe
//   vec[7:0]        captured vector, held until the next capture
//   vec_valid       vector available; vec_ready accepts it on a common edge
//   vec_ready       CPU core accept, only looked at during hand-off
//   busy            high whenever a sequence or re-arm is in progress
//   spurious        one-cycle pulse when the request was gone at capture time
// Parameters PULSE_CYC and GAP_CYC (legal 1..15) set pulse and gap widths.
module int_ack_master
  import int_ack_master_pkg::*;
#(
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned GAP_CYC   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       INT,
  input  logic       int_en,
  input  logic [7:0] D,
  output logic       INTA,
  output logic [7:0] vec,
  output logic       vec_valid,
  input  logic       vec_ready,
  output logic       busy,
  output logic       spurious
);

  logic             int_s;
  state_e           state;
  state_e           state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             inta_d;
  logic [7:0]       vec_d;
  logic             vec_valid_d;
  logic             busy_d;
  logic             spurious_d;

  // Only the synchronized request is used anywhere in the block.
  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (INT),
    .q     (int_s)
  );

  // State, counter and all outputs are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      INTA      <= INTA_IDLE;
      vec       <= 8'h00;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      spurious  <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      INTA      <= inta_d;
      vec       <= vec_d;
      vec_valid <= vec_valid_d;
      busy      <= busy_d;
      spurious  <= spurious_d;
    end
  end

  // Next-state and next-output logic; outputs derive from the next state so
  // that they change on the same edge as the state.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    vec_d      = vec;
    spurious_d = 1'b0;

    case (state)
      ST_IDLE: begin
        if (int_s && int_en) begin
          state_d = ST_ACK1;
          cnt_d   = cnt_load(PULSE_CYC);
        end
      end
      ST_ACK1: begin
        if (cnt == '0) begin
          state_d = ST_GAP;
          cnt_d   = cnt_load(GAP_CYC);
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt == '0) begin
          state_d = ST_ACK2;
          cnt_d   = cnt_load(PULSE_CYC);
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      ST_ACK2: begin
        // Last cycle of the second pulse: capture and flag a vanished request.
        if (cnt == '0) begin
          state_d    = ST_HANDOFF;
          vec_d      = D;
          spurious_d = ~int_s;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      ST_HANDOFF: begin
        if (vec_ready) begin
          state_d = ST_REARM;
          cnt_d   = cnt_load(GAP_CYC);
        end
      end
      ST_REARM: begin
        if (cnt == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    inta_d      = ((state_d == ST_ACK1) || (state_d == ST_ACK2)) ? ~INTA_IDLE : INTA_IDLE;
    vec_valid_d = (state_d == ST_HANDOFF);
    busy_d      = (state_d != ST_IDLE);
  end

endmodule

// File: doc/int_ack_master.md
INT_ACK_MASTER -- requirements
Module: int_ack_master

Interface
REQ-001 Parameter PULSE_CYC, default 2: cycles each INTA pulse is held low; legal range 1..15.
REQ-002 Parameter GAP_CYC, default 2: cycles INTA is high between pulses, and after hand-off before re-arm; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 INT  input  1  interrupt request from the controller; asynchronous, active-high.
REQ-006 int_en  input  1  CPU interrupt-enable flag; sampled only in IDLE.
REQ-007 D  input  8  data bus; controller drives the vector during the second INTA pulse.
REQ-008 INTA  output  1  acknowledge strobe to the controller; active-low, registered.
REQ-009 vec  output  8  captured interrupt vector; stable while vec_valid=1.
REQ-010 vec_valid  output  1  vector available to the CPU core.
REQ-011 vec_ready  input  1  CPU core accepts vec when vec_valid=1 and vec_ready=1 on the same rising edge.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 spurious  output  1  one-cycle pulse: synchronized INT was low when the vector was captured.

Function
REQ-014 INT passes through a two-flop synchronizer; int_s is the synchronized signal. No other logic uses raw INT.
REQ-015 The FSM has six states: IDLE, ACK1, GAP, ACK2, HANDOFF, REARM. A 4-bit down-counter times ACK1, GAP, ACK2 and REARM.
REQ-016 IDLE: INTA=1. Transition to ACK1 when int_s=1 and int_en=1. The counter loads PULSE_CYC-1.
REQ-017 ACK1: INTA=0 for exactly PULSE_CYC cycles, then transition to GAP. The counter loads GAP_CYC-1.
REQ-018 GAP: INTA=1 for exactly GAP_CYC cycles, then transition to ACK2. The counter loads PULSE_CYC-1.
REQ-019 ACK2: INTA=0 for exactly PULSE_CYC cycles.
REQ-020 On the last ACK2 cycle, D is registered into vec. The FSM then transitions to HANDOFF with vec_valid=1, and INTA rises on that same edge.
REQ-021 spurious pulses high for one cycle, on the same edge as the capture in REQ-020, if int_s=0 at that edge.
REQ-022 After ACK1 begins, the sequence is atomic. int_s falling and int_en falling are both ignored until HANDOFF.
REQ-023 HANDOFF: vec_valid stays 1 and vec stays constant until the handshake in REQ-011.
REQ-024 On acceptance: vec_valid drops to 0 on the next edge, the FSM enters REARM, and the counter loads GAP_CYC-1.
REQ-025 REARM: INTA=1 for GAP_CYC cycles, then return to IDLE. This guarantees minimum high time before the next ACK1.
REQ-026 Latency: int_s=1 in IDLE at edge N gives INTA=0 after edge N+1. Raw INT to first INTA low is at most 3 edges.
REQ-027 If int_s is still 1 when IDLE is re-entered, a new sequence starts immediately, i.e. back-to-back interrupts.
REQ-028 vec_ready is ignored in every state except HANDOFF.
REQ-029 vec holds its last captured value in all states. Its reset value is 8'h00.

Reset
REQ-030 rst_n=0 asynchronously forces: state=IDLE, counter=0, synchronizer flops=0, INTA=1, vec=8'h00, vec_valid=0, busy=0, spurious=0.
REQ-031 Reset asserted mid-sequence aborts the sequence. INTA returns high immediately. No vector is delivered.
REQ-032 After rst_n deasserts, no ACK1 begins earlier than the third rising edge, because of the synchronizer fill.

Structure
REQ-033 A shared package holds:
- the FSM state enum;
- the counter width constant CNT_W=4;
- the INTA idle level constant.
REQ-034 The synchronizer is one sub-module, sync_2ff, with ports clk, rst_n, d, q. It is reused for other asynchronous inputs in the codebase.
REQ-035 All outputs are driven directly from flops. There is no combinational path from any input to any output.

Verification
REQ-036 Basic sequence: defaults; INT=1, int_en=1; D=8'h4A during ACK2; vec_ready=1.
- INTA low 2 cycles, high 2 cycles, low 2 cycles.
- vec=8'h4A, vec_valid high for 1 cycle.
- spurious=0.
- busy is low again 2 cycles after acceptance.
REQ-037 Interrupts disabled: int_en=0 with INT=1 held for 20 cycles.
- INTA stays 1, busy stays 0.
- Raising int_en starts ACK1 within 1 cycle.
REQ-038 Spurious: INT drops during GAP; D=8'h4F.
- Both pulses still complete.
- vec=8'h4F, spurious pulses once.
REQ-039 Backpressure: vec_ready=0 for 10 cycles after capture of D=8'h21; INT held high.
- vec_valid and vec=8'h21 are held for all 10 cycles.
- No INTA pulse occurs until REARM has completed.
- A second sequence then follows.
REQ-040 Reset mid-sequence: rst_n pulsed low during ACK2.
- INTA=1 and vec_valid=0 immediately.
- vec=8'h00.
- The first INTA low occurs no earlier than the third edge after release.
REQ-041 Parameter sweep: PULSE_CYC=1, GAP_CYC=15.
- Pulse and gap widths match exactly, including the counter boundary values.
